// File: rtl/blue_anim_ctrl.sv
// Blue sprite animation sequencer: per-frame mode/facing/frame selection and
// per-pixel sprite ROM addressing with horizontal mirroring.
module blue_anim_ctrl #(
  parameter int SPR_W           = 47,
  parameter int SPR_H           = 41,
  parameter int ADDR_W          = 11,
  parameter int FRAMES_PER_STEP = 8,
  parameter int CNT_W           = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_sync,
  input  logic [2:0]        blue_state,
  input  logic              pix_valid,
  input  logic [5:0]        pix_x,
  input  logic [5:0]        pix_y,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        anim_sel,
  output logic [1:0]        frame_idx,
  output logic              facing_left,
  output logic              pix_sel_valid
);

  typedef enum logic [1:0] {
    S_STATIC = 2'd0,
    S_WALK   = 2'd1,
    S_JUMP   = 2'd2
  } state_t;

  localparam logic [5:0]        SPR_W_6  = 6'(SPR_W);
  localparam logic [5:0]        SPR_H_6  = 6'(SPR_H);
  localparam logic [ADDR_W-1:0] SPR_W_A  = ADDR_W'(SPR_W);
  localparam logic [CNT_W-1:0]  STEP_MAX = CNT_W'(FRAMES_PER_STEP - 1);

  state_t            state, next_state, req_state;
  logic [1:0]        next_frame;
  logic [CNT_W-1:0]  step_cnt, next_cnt;
  logic              next_facing;
  logic              in_range;
  logic              v1;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] addr_calc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_STATIC;
      frame_idx   <= 2'd0;
      step_cnt    <= '0;
      facing_left <= 1'b0;
    end else begin
      state       <= next_state;
      frame_idx   <= next_frame;
      step_cnt    <= next_cnt;
      facing_left <= next_facing;
    end
  end

  // Mode code 11 is treated as static; everything updates only on frame_sync.
  always_comb begin
    next_state  = state;
    next_frame  = frame_idx;
    next_cnt    = step_cnt;
    next_facing = facing_left;
    case (blue_state[1:0])
      2'b01:   req_state = S_WALK;
      2'b10:   req_state = S_JUMP;
      default: req_state = S_STATIC;
    endcase
    if (frame_sync) begin
      next_state  = req_state;
      next_facing = blue_state[2];
      if (req_state != state || state == S_JUMP) begin
        next_frame = 2'd0;
        next_cnt   = '0;
      end else if (step_cnt == STEP_MAX) begin
        next_cnt   = '0;
        next_frame = frame_idx + 2'd1;
      end else begin
        next_cnt = step_cnt + 1'b1;
      end
    end
  end

  assign anim_sel = state;

  // Uses the registered facing_left, so a pixel coinciding with frame_sync
  // still sees the old direction.
  assign in_range  = pix_valid && (pix_x < SPR_W_6) && (pix_y < SPR_H_6);
  assign col       = facing_left ? (SPR_W_A - 1'b1 - ADDR_W'(pix_x)) : ADDR_W'(pix_x);
  assign addr_calc = ADDR_W'(pix_y) * SPR_W_A + col;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr      <= '0;
      v1            <= 1'b0;
      pix_sel_valid <= 1'b0;
    end else begin
      rom_addr      <= in_range ? addr_calc : '0;
      v1            <= in_range;
      pix_sel_valid <= v1;
    end
  end

endmodule

// File: tb/tb_blue_anim_ctrl.sv
// Directed self-checking bench for blue_anim_ctrl with hand-computed expectations.
module tb_blue_anim_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_sync;
  logic [2:0]  blue_state;
  logic        pix_valid;
  logic [5:0]  pix_x;
  logic [5:0]  pix_y;
  logic [10:0] rom_addr;
  logic [1:0]  anim_sel;
  logic [1:0]  frame_idx;
  logic        facing_left;
  logic        pix_sel_valid;

  int checks   = 0;
  int failures = 0;

  blue_anim_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_sync   (frame_sync),
    .blue_state   (blue_state),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .rom_addr     (rom_addr),
    .anim_sel     (anim_sel),
    .frame_idx    (frame_idx),
    .facing_left  (facing_left),
    .pix_sel_valid(pix_sel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives inputs after a falling edge and returns at the next falling edge,
  // so exactly one rising edge has seen them.
  task automatic applyStimulus(input logic fs, input logic [2:0] st, input logic pv,
                               input logic [5:0] x, input logic [5:0] y);
    frame_sync = fs;
    blue_state = st;
    pix_valid  = pv;
    pix_x      = x;
    pix_y      = y;
    @(negedge clk);
  endtask

  task automatic pulseFrames(input int n, input logic [2:0] st);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, st, 1'b0, 6'd0, 6'd0);
      applyStimulus(1'b0, st, 1'b0, 6'd0, 6'd0);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 3'b000, 1'b0, 6'd0, 6'd0);
    applyStimulus(1'b0, 3'b000, 1'b0, 6'd0, 6'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frame_sync = 1'b0; blue_state = 3'b000; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    @(negedge clk);
    doReset();

    checkOutput("reset_anim_sel", anim_sel, 0);
    checkOutput("reset_frame_idx", frame_idx, 0);
    checkOutput("reset_facing", facing_left, 0);
    checkOutput("reset_rom_addr", rom_addr, 0);
    checkOutput("reset_psv", pix_sel_valid, 0);

    pulseFrames(7, 3'b000);
    checkOutput("static_7_pulses", frame_idx, 0);
    pulseFrames(1, 3'b000);
    checkOutput("static_8_pulses", frame_idx, 1);
    pulseFrames(8, 3'b000);
    checkOutput("static_16_pulses", frame_idx, 2);
    pulseFrames(16, 3'b000);
    checkOutput("static_32_wrap", frame_idx, 0);

    pulseFrames(1, 3'b100);
    checkOutput("facing_set", facing_left, 1);
    applyStimulus(1'b0, 3'b100, 1'b1, 6'd0, 6'd0);
    checkOutput("mirror_0_0", rom_addr, 46);
    applyStimulus(1'b0, 3'b100, 1'b1, 6'd46, 6'd40);
    checkOutput("mirror_46_40", rom_addr, 1880);
    pulseFrames(1, 3'b000);
    applyStimulus(1'b0, 3'b000, 1'b1, 6'd46, 6'd40);
    checkOutput("plain_46_40", rom_addr, 1926);

    pulseFrames(1, 3'b001);
    checkOutput("walk_enter_sel", anim_sel, 1);
    checkOutput("walk_enter_frame", frame_idx, 0);
    pulseFrames(16, 3'b001);
    checkOutput("walk_frame2", frame_idx, 2);
    pulseFrames(1, 3'b010);
    checkOutput("jump_sel", anim_sel, 2);
    checkOutput("jump_frame", frame_idx, 0);
    pulseFrames(9, 3'b010);
    checkOutput("jump_hold_frame", frame_idx, 0);
    pulseFrames(1, 3'b001);
    checkOutput("walk_back_sel", anim_sel, 1);
    checkOutput("walk_back_frame", frame_idx, 0);

    applyStimulus(1'b0, 3'b110, 1'b0, 6'd0, 6'd0);
    applyStimulus(1'b0, 3'b111, 1'b0, 6'd0, 6'd0);
    applyStimulus(1'b0, 3'b010, 1'b0, 6'd0, 6'd0);
    checkOutput("nosync_anim_sel", anim_sel, 1);
    checkOutput("nosync_frame", frame_idx, 0);
    checkOutput("nosync_facing", facing_left, 0);

    pulseFrames(8, 3'b001);
    checkOutput("walk_frame1", frame_idx, 1);
    pulseFrames(7, 3'b101);
    checkOutput("dir_only_facing", facing_left, 1);
    checkOutput("dir_only_frame", frame_idx, 1);
    pulseFrames(1, 3'b101);
    checkOutput("dir_only_continue", frame_idx, 2);

    pulseFrames(1, 3'b011);
    checkOutput("code11_static", anim_sel, 0);
    checkOutput("code11_facing", facing_left, 0);

    applyStimulus(1'b0, 3'b011, 1'b1, 6'd47, 6'd0);
    checkOutput("oor_x_addr", rom_addr, 0);
    applyStimulus(1'b0, 3'b011, 1'b1, 6'd0, 6'd41);
    checkOutput("oor_y_addr", rom_addr, 0);
    checkOutput("oor_x_psv", pix_sel_valid, 0);
    applyStimulus(1'b0, 3'b011, 1'b0, 6'd0, 6'd0);
    checkOutput("oor_y_psv", pix_sel_valid, 0);
    applyStimulus(1'b0, 3'b011, 1'b1, 6'd5, 6'd3);
    checkOutput("inrange_addr", rom_addr, 146);
    checkOutput("inrange_psv_1cyc", pix_sel_valid, 0);
    applyStimulus(1'b0, 3'b011, 1'b0, 6'd0, 6'd0);
    checkOutput("inrange_psv_2cyc", pix_sel_valid, 1);
    applyStimulus(1'b0, 3'b011, 1'b0, 6'd0, 6'd0);
    checkOutput("inrange_psv_3cyc", pix_sel_valid, 0);

    applyStimulus(1'b1, 3'b100, 1'b1, 6'd0, 6'd0);
    checkOutput("sync_pixel_old_dir", rom_addr, 0);
    applyStimulus(1'b0, 3'b100, 1'b1, 6'd0, 6'd0);
    checkOutput("sync_pixel_new_dir", rom_addr, 46);

    doReset();
    pulseFrames(24, 3'b100);
    checkOutput("pre_rst_frame3", frame_idx, 3);
    checkOutput("pre_rst_facing", facing_left, 1);
    applyStimulus(1'b0, 3'b100, 1'b1, 6'd1, 6'd1);
    applyStimulus(1'b0, 3'b100, 1'b1, 6'd2, 6'd1);
    checkOutput("burst_psv", pix_sel_valid, 1);
    rst = 1'b1;
    applyStimulus(1'b0, 3'b100, 1'b1, 6'd3, 6'd1);
    checkOutput("rst_anim_sel", anim_sel, 0);
    checkOutput("rst_frame", frame_idx, 0);
    checkOutput("rst_facing", facing_left, 0);
    checkOutput("rst_addr", rom_addr, 0);
    checkOutput("rst_psv", pix_sel_valid, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 3'b100, 1'b0, 6'd0, 6'd0);
    checkOutput("flush_psv", pix_sel_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
